// File: rtl/pipeline_debug_controller.sv
// Run/step/halt sequencer and state dumper for the 5-stage pipeline.
// Gates the pipeline clock enable, stops on HALT_OPCODE in ID, and on DUMP freezes
// the core and streams registers then data-memory words, LSB first, over valid/ready.
// Optional feature macro: PIPE_DBG_CYCLE_COUNT_EN (cycle counter plus a trailer word in the dump).
module pipeline_debug_controller #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned MEM_WORDS   = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  output logic        cmd_ready,
  input  logic [31:0] instruction_ID,
  output logic        pipe_en,
  output logic        debugMode,
  output logic [31:0] DebugAddress,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic        busy,
  output logic [31:0] cycle_count
);

  localparam logic [1:0] CMD_RUN  = 2'b00;
  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_DUMP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

`ifdef PIPE_DBG_CYCLE_COUNT_EN
  localparam int unsigned TRAILER_WORDS = 1;
`else
  localparam int unsigned TRAILER_WORDS = 0;
`endif
  localparam int unsigned TOTAL_WORDS = NUM_REGS + MEM_WORDS + TRAILER_WORDS;
  localparam int unsigned WORD_W      = $clog2(TOTAL_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, RUN, STEP, D_SETUP, D_LOAD, D_SEND, DONE
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] word_q, word_n, next_word;
  logic [1:0]        byte_q, byte_n;
  logic [31:0]       shift_q, shift_n;
  logic [31:0]       load_word;
  logic              halt_op;
  logic              pipe_en_n, debug_mode_n, tx_valid_n, halted_n;
  logic [31:0]       debug_addr_n;
  logic [4:0]        reg_sel_n;
  logic [7:0]        tx_data_n;
  logic              unused_id;

  assign halt_op   = (instruction_ID[31:26] == HALT_OPCODE);
  assign unused_id = ^instruction_ID[25:0];
  assign next_word = word_q + WORD_W'(1);

  // Source of the word being loaded: registers, then memory, then the counter trailer
  always_comb begin
    if (word_q < WORD_W'(NUM_REGS))                  load_word = reg_data;
    else if (word_q < WORD_W'(NUM_REGS + MEM_WORDS)) load_word = mem_data;
    else                                             load_word = cycle_count;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    word_n       = word_q;
    byte_n       = byte_q;
    shift_n      = shift_q;
    pipe_en_n    = 1'b0;
    debug_mode_n = debugMode;
    debug_addr_n = DebugAddress;
    reg_sel_n    = reg_sel;
    tx_valid_n   = tx_valid;
    tx_data_n    = tx_data;
    halted_n     = halted;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_RUN:  begin state_n = RUN; pipe_en_n = 1'b1; halted_n = 1'b0; end
            CMD_STEP: begin state_n = STEP; pipe_en_n = 1'b1; end
            CMD_DUMP: begin
              state_n      = D_SETUP;
              word_n       = '0;
              byte_n       = '0;
              reg_sel_n    = '0;
              debug_mode_n = 1'b0;
            end
            default:  halted_n = 1'b1;
          endcase
        end
      end
      RUN: begin
        // Halt wins over anything else arriving this cycle; other commands are swallowed
        if (halt_op || (cmd_valid && cmd == CMD_HALT)) begin
          state_n  = IDLE;
          halted_n = 1'b1;
        end else begin
          pipe_en_n = 1'b1;
        end
      end
      STEP: begin
        state_n = IDLE;
        if (halt_op) halted_n = 1'b1;
      end
      D_SETUP: state_n = D_LOAD;
      D_LOAD: begin
        shift_n    = load_word;
        tx_data_n  = load_word[7:0];
        tx_valid_n = 1'b1;
        byte_n     = '0;
        state_n    = D_SEND;
      end
      D_SEND: begin
        if (tx_ready) begin
          if (byte_q == 2'd3) begin
            tx_valid_n = 1'b0;
            if (word_q == WORD_W'(TOTAL_WORDS - 1)) begin
              state_n      = DONE;
              debug_mode_n = 1'b0;
            end else begin
              state_n = D_SETUP;
              word_n  = next_word;
              if (next_word < WORD_W'(NUM_REGS)) begin
                reg_sel_n    = 5'(next_word);
                debug_mode_n = 1'b0;
              end else if (next_word < WORD_W'(NUM_REGS + MEM_WORDS)) begin
                debug_mode_n = 1'b1;
                debug_addr_n = 32'(next_word - WORD_W'(NUM_REGS));
              end else begin
                debug_mode_n = 1'b0;
              end
            end
          end else begin
            byte_n    = byte_q + 2'd1;
            shift_n   = {8'h00, shift_q[31:8]};
            tx_data_n = shift_q[15:8];
          end
        end
      end
      DONE: begin
        state_n      = IDLE;
        debug_mode_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      word_q       <= '0;
      byte_q       <= '0;
      shift_q      <= '0;
      pipe_en      <= 1'b0;
      debugMode    <= 1'b0;
      DebugAddress <= '0;
      reg_sel      <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      halted       <= 1'b0;
      busy         <= 1'b0;
      cmd_ready    <= 1'b1;
    end else begin
      state        <= state_n;
      word_q       <= word_n;
      byte_q       <= byte_n;
      shift_q      <= shift_n;
      pipe_en      <= pipe_en_n;
      debugMode    <= debug_mode_n;
      DebugAddress <= debug_addr_n;
      reg_sel      <= reg_sel_n;
      tx_valid     <= tx_valid_n;
      tx_data      <= tx_data_n;
      halted       <= halted_n;
      busy         <= (state_n != IDLE);
      cmd_ready    <= (state_n == IDLE) || (state_n == RUN);
    end
  end

`ifdef PIPE_DBG_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q;

  // Count cycles in which the core advanced; wraps naturally
  always_ff @(posedge clk) begin
    if (!reset_n)     cycle_count_q <= '0;
    else if (pipe_en) cycle_count_q <= cycle_count_q + 32'd1;
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = '0;
`endif

endmodule
